hamming_secded_decoder: RTL and testbench

Hardware SECDED decoder engine, the decode counterpart of the (16,11) Hamming encode program run on the core.
- On a req/done handshake it reads N_WORDS 16-bit codewords from the byte-wide data memory and checks each one.
- It corrects single-bit errors and flags double-bit errors.
- It writes the 11-bit data words plus status flags back to memory.
- It sits beside the core on the dat_mem port, which is muxed by the top level.

---
 rtl/hamming_pkg.sv | 22 ++
 rtl/secded_dec.sv | 35 +++
 rtl/hamming_secded_decoder.sv | 161 ++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the (16,11) SECDED decoder engine.
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAP,
    ST_DEC,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SEC = 2'b01;
  localparam logic [1:0] FLAG_DED = 2'b10;

  // Codeword bit positions of d1..d11, in ascending data-bit order.
  localparam int unsigned DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/secded_dec.sv
// Combinational (16,11) SECDED check/correct: codeword in, data and flag out.
module secded_dec
  import hamming_pkg::*;
(
  input  logic [15:0] cw,
  output logic [10:0] data,
  output logic [1:0]  flag
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn   = '0;
    par   = ^cw;
    fixed = cw;
    flag  = FLAG_OK;
    data  = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    // Odd overall parity means one flipped bit; syndrome 0 points at p0.
    if (par) begin
      fixed[syn] = ~fixed[syn];
      flag       = FLAG_SEC;
    end else if (syn != 4'd0) begin
      flag = FLAG_DED;
    end
    for (int unsigned k = 0; k < 11; k++) begin
      data[k] = fixed[DATA_POS[k]];
    end
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Memory-mapped SECDED decoder engine: reads N_WORDS codewords, writes data+flag.
// Optional error counters are enabled with HAMMING_ERR_COUNT_EN.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned N_WORDS  = 15,
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
`ifdef HAMMING_ERR_COUNT_EN
  ,
  output logic [7:0]    err_single_cnt,
  output logic [7:0]    err_double_cnt
`endif
);

  localparam int unsigned IW = $clog2(N_WORDS + 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    lo_q, lo_d;
  logic [15:0]   cw_q, cw_d;
  logic [10:0]   data_q, data_d;
  logic [1:0]    flag_q, flag_d;

  logic [10:0]   dec_data;
  logic [1:0]    dec_flag;
  logic [AW-1:0] src_addr, dst_addr;

  secded_dec u_dec (
    .cw   (cw_q),
    .data (dec_data),
    .flag (dec_flag)
  );

  assign src_addr = AW'(SRC_BASE + 2 * idx_q);
  assign dst_addr = AW'(DST_BASE + 2 * idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    cw_d      = cw_q;
    data_d    = data_q;
    flag_d    = flag_q;
    done      = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RD_LO;
          idx_d   = '0;
        end
      end
      ST_RD_LO: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_addr;
        state_d   = ST_RD_HI;
      end
      ST_RD_HI: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_addr + AW'(1);
        lo_d      = mem_rdata;
        state_d   = ST_CAP;
      end
      ST_CAP: begin
        cw_d    = {mem_rdata, lo_q};
        state_d = ST_DEC;
      end
      ST_DEC: begin
        data_d  = dec_data;
        flag_d  = dec_flag;
        state_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = data_q[7:0];
        state_d   = ST_WR_HI;
      end
      ST_WR_HI: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_addr + AW'(1);
        mem_wdata = {flag_q, 3'b000, data_q[10:8]};
        if (idx_q == IW'(N_WORDS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_LO;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      cw_q    <= '0;
      data_q  <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      cw_q    <= cw_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

`ifdef HAMMING_ERR_COUNT_EN
  logic [7:0] sec_cnt_q, sec_cnt_d;
  logic [7:0] ded_cnt_q, ded_cnt_d;

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (state_q == ST_IDLE && req) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (state_q == ST_DEC) begin
      if (dec_flag == FLAG_SEC && sec_cnt_q != 8'hFF) sec_cnt_d = sec_cnt_q + 8'd1;
      if (dec_flag == FLAG_DED && ded_cnt_q != 8'hFF) ded_cnt_d = ded_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign err_single_cnt = sec_cnt_q;
  assign err_double_cnt = ded_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder with a byte-wide synchronous memory model.
module tb_hamming_secded_decoder;

  localparam int N = 15;
  localparam int POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
`ifdef HAMMING_ERR_COUNT_EN
  logic [7:0] err_single_cnt;
  logic [7:0] err_double_cnt;
`endif

  logic [7:0] mem [0:255];
  logic [7:0] exp_lo [N];
  logic [7:0] exp_hi [N];
  int errors = 0;
  int checks = 0;
  int n_sec, n_ded;

  hamming_secded_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef HAMMING_ERR_COUNT_EN
    ,
    .err_single_cnt (err_single_cnt),
    .err_double_cnt (err_double_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic b;
    c = '0;
    for (int k = 0; k < 11; k++) c[POS[k]] = d[k];
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int j = 1; j < 16; j++)
        if ((j & p) != 0 && j != p) b = b ^ c[j];
      c[p] = b;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    for (int k = 0; k < 11; k++) d[k] = c[POS[k]];
    return d;
  endfunction

  function automatic logic [18:0] bus();
    return {done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata};
  endfunction

  task automatic put_word(input int w, input logic [15:0] c, input logic [10:0] d, input logic [1:0] f);
    mem[30 + 2 * w]     = c[7:0];
    mem[30 + 2 * w + 1] = c[15:8];
    exp_lo[w] = d[7:0];
    exp_hi[w] = {f, 3'b000, d[10:8]};
  endtask

  // Drives one request from edge 0 and checks every cycle of the bus; optional reset abort.
  task automatic run(input int abort_at);
    logic [18:0] ev;
    int w, ph;
    @(negedge clk);
    req = 1'b1;
    for (int c = 1; c <= 6 * N + 1; c++) begin
      @(posedge clk);
      #1;
      if (c <= 6 * N) begin
        w  = (c - 1) / 6;
        ph = (c - 1) % 6;
        case (ph)
          0:       ev = {3'b010, 8'(30 + 2 * w), 8'h00};
          1:       ev = {3'b010, 8'(31 + 2 * w), 8'h00};
          4:       ev = {3'b001, 8'(2 * w), exp_lo[w]};
          5:       ev = {3'b001, 8'(2 * w + 1), exp_hi[w]};
          default: ev = '0;
        endcase
        chk($sformatf("bus_c%0d", c), 32'(bus()), 32'(ev));
      end else begin
        chk("done_rise", 32'(bus()), 32'({1'b1, 18'b0}));
      end
      if (c == abort_at) begin
        reset = 1'b0;
        req   = 1'b0;
        #1;
        chk("abort_outs", 32'(bus()), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    logic [10:0] d;
    logic [15:0] c;
    int ne, b1, b2;

    reset = 1'b0;
    req   = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(bus()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Run 1: directed vectors then random codewords with 0..2 injected flips.
    put_word(0, 16'hFFFF, 11'h7FF, 2'b00);
    put_word(1, 16'hFFDF, 11'h7FF, 2'b01);
    put_word(2, 16'hFFFE, 11'h7FF, 2'b01);
    exp_lo[3] = 8'hED; exp_hi[3] = 8'h87;
    mem[36] = 8'hDF; mem[37] = 8'hFD;
    n_sec = 2;
    n_ded = 1;
    for (int w = 4; w < N; w++) begin
      d  = 11'($urandom);
      c  = encode(d);
      ne = int'($urandom_range(0, 2));
      b1 = int'($urandom_range(0, 15));
      b2 = (b1 + int'($urandom_range(1, 15))) % 16;
      if (ne >= 1) c[b1] = ~c[b1];
      if (ne == 2) c[b2] = ~c[b2];
      if (ne == 0)      put_word(w, c, d, 2'b00);
      else if (ne == 1) begin put_word(w, c, d, 2'b01); n_sec++; end
      else              begin put_word(w, c, extract(c), 2'b10); n_ded++; end
    end
    for (int a = 0; a < 2 * N; a++) mem[a] = 8'hAA;
    run(0);
    for (int w = 0; w < N; w++) begin
      chk($sformatf("mem_lo%0d", w), 32'(mem[2 * w]), 32'(exp_lo[w]));
      chk($sformatf("mem_hi%0d", w), 32'(mem[2 * w + 1]), 32'(exp_hi[w]));
    end
`ifdef HAMMING_ERR_COUNT_EN
    chk("sec_cnt", 32'(err_single_cnt), 32'(n_sec));
    chk("ded_cnt", 32'(err_double_cnt), 32'(n_ded));
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("done_hold", 32'({done, mem_rd_en, mem_wr_en}), 32'(3'b100));
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("done_clear", 32'(done), 32'd0);

    // Run 2: zero codewords, aborted by reset during word 3.
    for (int a = 0; a < 2 * N; a++) begin
      mem[a]      = 8'hAA;
      mem[30 + a] = 8'h00;
    end
    for (int w = 0; w < N; w++) begin
      exp_lo[w] = '0;
      exp_hi[w] = '0;
    end
    run(20);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", 32'(bus()), 32'd0);
    for (int a = 0; a < 2 * N; a++)
      chk($sformatf("abort_mem%0d", a), 32'(mem[a]), (a < 6) ? 32'h00 : 32'hAA);
    @(negedge clk);
    reset = 1'b1;

    // Run 3: full zero run after the abort restarts at word 0.
    run(0);
    for (int a = 0; a < 2 * N; a++)
      chk($sformatf("zero_mem%0d", a), 32'(mem[a]), 32'h00);
`ifdef HAMMING_ERR_COUNT_EN
    chk("sec_cnt_zero", 32'(err_single_cnt), 32'd0);
    chk("ded_cnt_zero", 32'(err_double_cnt), 32'd0);
`endif
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", 32'(bus()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
